// File: rtl/ysyx_rf_scoreboard.sv
// Integer register file with a per-register pending-write counter scoreboard.
// Define YSYX_RF_BYPASS_EN for same-cycle write-through of writeback data and busy bits.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_REG_NUM
`define YSYX_REG_NUM 32
`endif

module ysyx_rf_scoreboard #(
  parameter int unsigned XLEN    = `YSYX_XLEN,
  parameter int unsigned REG_LEN = `YSYX_REG_LEN,
  parameter int unsigned REG_NUM = `YSYX_REG_NUM,
  parameter int unsigned CNT_W   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [REG_LEN-1:0] rs1,
  input  logic [REG_LEN-1:0] rs2,
  output logic [XLEN-1:0]    rdata1,
  output logic [XLEN-1:0]    rdata2,
  output logic [REG_NUM-1:0] rf_table,
  input  logic               issue_valid,
  input  logic               issue_wen,
  input  logic [REG_LEN-1:0] issue_rd,
  output logic               issue_ready,
  input  logic               wb_valid,
  input  logic [REG_LEN-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  output logic               wb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  r_regs [REG_NUM];
  logic [CNT_W-1:0] r_cnt  [REG_NUM];
  logic             r_wb_underflow;

  logic w_rel;
  logic w_res;
  logic w_both;
  logic w_issue_full;

  assign w_rel        = wb_valid && (wb_rd != '0);
  assign w_issue_full = issue_wen && (issue_rd != '0) && (r_cnt[issue_rd] == CNT_MAX);
  // A saturated counter can still take a reservation when the same register retires now.
  assign issue_ready  = !w_issue_full || (wb_valid && (wb_rd == issue_rd));
  assign w_res        = issue_valid && issue_wen && (issue_rd != '0) && issue_ready;
  assign w_both       = w_res && w_rel && (issue_rd == wb_rd);
  assign wb_underflow = r_wb_underflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_wb_underflow <= 1'b0;
    end else begin
      r_wb_underflow <= w_rel && (r_cnt[wb_rd] == '0);
      if (w_rel) r_regs[wb_rd] <= wb_data;
      if (flush) begin
        for (int unsigned i = 0; i < REG_NUM; i++) r_cnt[i] <= '0;
      end else if (!w_both) begin
        if (w_res) r_cnt[issue_rd] <= r_cnt[issue_rd] + CNT_ONE;
        if (w_rel && (r_cnt[wb_rd] != '0)) r_cnt[wb_rd] <= r_cnt[wb_rd] - CNT_ONE;
      end
    end
  end

  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : r_regs[rs1];
    rdata2 = (rs2 == '0) ? '0 : r_regs[rs2];
`ifdef YSYX_RF_BYPASS_EN
    if (w_rel && (wb_rd == rs1)) rdata1 = wb_data;
    if (w_rel && (wb_rd == rs2)) rdata2 = wb_data;
`endif
  end

  always_comb begin
    rf_table = '0;
    for (int unsigned i = 1; i < REG_NUM; i++) rf_table[i] = (r_cnt[i] != '0);
`ifdef YSYX_RF_BYPASS_EN
    // Last outstanding write retiring now frees the register for decode this cycle.
    if (w_rel && (r_cnt[wb_rd] == CNT_ONE) && !w_both) rf_table[wb_rd] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ysyx_rf_scoreboard.sv
// Self-checking bench for ysyx_rf_scoreboard: directed scenarios plus a randomized model run.
module tb_ysyx_rf_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2;
  logic [31:0] rdata1, rdata2;
  logic [31:0] rf_table;
  logic        issue_valid, issue_wen, issue_ready;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        wb_underflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  ysyx_rf_scoreboard dut (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2), .rf_table(rf_table),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .wb_underflow(wb_underflow)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic idle();
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; rs1 = 5; rs2 = 0;
    tick(); tick(); reset = 0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL reset_rdata1: got %h want %h", rdata1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rdata2 !== exp) begin errors++; $display("FAIL reset_rdata2: got %h want %h", rdata2, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rf_table !== exp) begin errors++; $display("FAIL reset_table: got %h want %h", rf_table, exp); end
    exp = exp_q.pop_front(); checks++;
    if (issue_ready !== exp[0]) begin errors++; $display("FAIL reset_ready: got %b want %b", issue_ready, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL reset_uf: got %b want %b", wb_underflow, exp[0]); end
    tick();
  endtask

  task automatic test_issue_wb();
    idle(); issue_valid = 1; issue_wen = 1; issue_rd = 3; rs1 = 3;
    exp_q.push_back(1); exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (issue_ready !== exp[0]) begin errors++; $display("FAIL iw_ready: got %b want %b", issue_ready, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rf_table[3] !== exp[0]) begin errors++; $display("FAIL iw_latency: got %b want %b", rf_table[3], exp[0]); end
    tick();
    idle(); wb_valid = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
`ifdef YSYX_RF_BYPASS_EN
    exp_q.push_back(0); exp_q.push_back(32'hDEADBEEF);
`else
    exp_q.push_back(1); exp_q.push_back(0);
`endif
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table[3] !== exp[0]) begin errors++; $display("FAIL iw_busy: got %b want %b", rf_table[3], exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL iw_wbcycle_data: got %h want %h", rdata1, exp); end
    tick();
    idle();
    exp_q.push_back(0); exp_q.push_back(32'hDEADBEEF);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table[3] !== exp[0]) begin errors++; $display("FAIL iw_clear: got %b want %b", rf_table[3], exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL iw_data: got %h want %h", rdata1, exp); end
    tick();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      idle(); issue_valid = 1; issue_wen = 1; issue_rd = 7;
      exp_q.push_back(1);
      @(negedge clock);
      exp = exp_q.pop_front(); checks++;
      if (issue_ready !== exp[0]) begin errors++; $display("FAIL sat_ready%0d: got %b want %b", k, issue_ready, exp[0]); end
      tick();
    end
    idle(); issue_wen = 1; issue_rd = 7;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (issue_ready !== exp[0]) begin errors++; $display("FAIL sat_full: got %b want %b", issue_ready, exp[0]); end
    issue_rd = 8; #1;
    exp = exp_q.pop_front(); checks++;
    if (issue_ready !== exp[0]) begin errors++; $display("FAIL sat_other: got %b want %b", issue_ready, exp[0]); end
    issue_rd = 7; issue_valid = 1; wb_valid = 1; wb_rd = 7; wb_data = 32'h70; #1;
    exp = exp_q.pop_front(); checks++;
    if (issue_ready !== exp[0]) begin errors++; $display("FAIL sat_release: got %b want %b", issue_ready, exp[0]); end
    tick();
    idle(); issue_valid = 1; issue_wen = 1; issue_rd = 7;
    exp_q.push_back(32'h80);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table !== exp) begin errors++; $display("FAIL sat_table: got %h want %h", rf_table, exp); end
    tick();
    for (int k = 0; k < 3; k++) begin
      idle(); wb_valid = 1; wb_rd = 7; wb_data = 32'h71 + k;
`ifdef YSYX_RF_BYPASS_EN
      exp_q.push_back((k < 2) ? 1 : 0);
`else
      exp_q.push_back(1);
`endif
      @(negedge clock);
      exp = exp_q.pop_front(); checks++;
      if (rf_table[7] !== exp[0]) begin errors++; $display("FAIL sat_drain%0d: got %b want %b", k, rf_table[7], exp[0]); end
      tick();
    end
    idle(); rs1 = 7;
    exp_q.push_back(0); exp_q.push_back(32'h73);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table[7] !== exp[0]) begin errors++; $display("FAIL sat_cleared: got %b want %b", rf_table[7], exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL sat_data: got %h want %h", rdata1, exp); end
    tick();
  endtask

  task automatic test_same_cycle();
    idle(); issue_valid = 1; issue_wen = 1; issue_rd = 4;
    tick();
    wb_valid = 1; wb_rd = 4; wb_data = 32'h11;
    exp_q.push_back(1);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table[4] !== exp[0]) begin errors++; $display("FAIL same_busy: got %b want %b", rf_table[4], exp[0]); end
    tick();
    idle(); rs1 = 4;
    exp_q.push_back(1); exp_q.push_back(32'h11);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table[4] !== exp[0]) begin errors++; $display("FAIL same_cnt: got %b want %b", rf_table[4], exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL same_data: got %h want %h", rdata1, exp); end
    tick();
    wb_valid = 1; wb_rd = 4; wb_data = 32'h12;
    tick();
    idle();
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table[4] !== exp[0]) begin errors++; $display("FAIL same_drain: got %b want %b", rf_table[4], exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL same_uf: got %b want %b", wb_underflow, exp[0]); end
    tick();
  endtask

  task automatic test_underflow();
    idle(); wb_valid = 1; wb_rd = 9; wb_data = 32'h99; rs1 = 9;
    exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL uf_early: got %b want %b", wb_underflow, exp[0]); end
    tick();
    idle();
    exp_q.push_back(1); exp_q.push_back(32'h99); exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL uf_pulse: got %b want %b", wb_underflow, exp[0]); end
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL uf_data: got %h want %h", rdata1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rf_table !== exp) begin errors++; $display("FAIL uf_table: got %h want %h", rf_table, exp); end
    tick();
    exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL uf_one_cycle: got %b want %b", wb_underflow, exp[0]); end
    tick();
    wb_valid = 1; wb_rd = 0; wb_data = 32'h55; rs1 = 0;
    exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL x0_bypass: got %h want %h", rdata1, exp); end
    tick();
    idle();
    exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL x0_data: got %h want %h", rdata1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL x0_uf: got %b want %b", wb_underflow, exp[0]); end
    tick();
  endtask

  task automatic test_flush();
    idle(); issue_valid = 1; issue_wen = 1; issue_rd = 2; tick();
    issue_rd = 6; tick();
    idle();
    exp_q.push_back(32'h44);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table !== exp) begin errors++; $display("FAIL fl_pre: got %h want %h", rf_table, exp); end
    tick();
    flush = 1; issue_valid = 1; issue_wen = 1; issue_rd = 10;
    wb_valid = 1; wb_rd = 5; wb_data = 32'hAB;
    tick();
    idle(); rs1 = 5; rs2 = 3;
    exp_q.push_back(0); exp_q.push_back(32'hAB); exp_q.push_back(32'hDEADBEEF); exp_q.push_back(1);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rf_table !== exp) begin errors++; $display("FAIL fl_table: got %h want %h", rf_table, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL fl_wbdata: got %h want %h", rdata1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rdata2 !== exp) begin errors++; $display("FAIL fl_retained: got %h want %h", rdata2, exp); end
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL fl_uf: got %b want %b", wb_underflow, exp[0]); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); issue_valid = 1; issue_wen = 1; issue_rd = 12; tick();
    reset = 1; issue_rd = 14; wb_valid = 1; wb_rd = 13; wb_data = 32'h1;
    tick();
    reset = 0; idle(); rs1 = 3; rs2 = 13;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (rdata1 !== exp) begin errors++; $display("FAIL rst_x3: got %h want %h", rdata1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rdata2 !== exp) begin errors++; $display("FAIL rst_x13: got %h want %h", rdata2, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rf_table !== exp) begin errors++; $display("FAIL rst_table: got %h want %h", rf_table, exp); end
    exp = exp_q.pop_front(); checks++;
    if (wb_underflow !== exp[0]) begin errors++; $display("FAIL rst_uf: got %b want %b", wb_underflow, exp[0]); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] m_regs [32];
    logic [1:0]  m_cnt [32];
    logic        m_uf, res, rel, e_ready;
    logic [31:0] e_tab, e_r1, e_r2;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
    m_uf = 0;
    idle(); reset = 1; tick(); reset = 0;
    for (int c = 0; c < 400; c++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_wen   = 1'($urandom_range(0, 3) != 0);
      issue_rd    = 5'($urandom_range(0, 3));
      wb_valid    = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      rs1         = 5'($urandom_range(0, 3));
      rs2         = 5'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 15) == 0);
      if (wb_valid && issue_valid && issue_wen && wb_rd == issue_rd && m_cnt[wb_rd] == 0) wb_valid = 0;
      e_ready = !(issue_wen && issue_rd != 0 && m_cnt[issue_rd] == 2'd3) || (wb_valid && wb_rd == issue_rd);
      res = issue_valid && issue_wen && issue_rd != 0 && e_ready;
      rel = wb_valid && wb_rd != 0;
      e_tab = 0;
      for (int i = 1; i < 32; i++) e_tab[i] = (m_cnt[i] != 0);
      e_r1 = (rs1 == 0) ? 0 : m_regs[rs1];
      e_r2 = (rs2 == 0) ? 0 : m_regs[rs2];
`ifdef YSYX_RF_BYPASS_EN
      if (rel && m_cnt[wb_rd] == 1 && !(res && issue_rd == wb_rd)) e_tab[wb_rd] = 0;
      if (rel && wb_rd == rs1) e_r1 = wb_data;
      if (rel && wb_rd == rs2) e_r2 = wb_data;
`endif
      exp_q.push_back({31'd0, e_ready}); exp_q.push_back(e_tab);
      exp_q.push_back(e_r1); exp_q.push_back(e_r2); exp_q.push_back({31'd0, m_uf});
      @(negedge clock);
      exp = exp_q.pop_front(); checks++;
      if (issue_ready !== exp[0]) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, issue_ready, exp[0]); end
      exp = exp_q.pop_front(); checks++;
      if (rf_table !== exp) begin errors++; $display("FAIL rnd_table c%0d: got %h want %h", c, rf_table, exp); end
      exp = exp_q.pop_front(); checks++;
      if (rdata1 !== exp) begin errors++; $display("FAIL rnd_rdata1 c%0d: got %h want %h", c, rdata1, exp); end
      exp = exp_q.pop_front(); checks++;
      if (rdata2 !== exp) begin errors++; $display("FAIL rnd_rdata2 c%0d: got %h want %h", c, rdata2, exp); end
      exp = exp_q.pop_front(); checks++;
      if (wb_underflow !== exp[0]) begin errors++; $display("FAIL rnd_uf c%0d: got %b want %b", c, wb_underflow, exp[0]); end
      m_uf = rel && (m_cnt[wb_rd] == 0);
      if (rel) m_regs[wb_rd] = wb_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else if (!(res && rel && issue_rd == wb_rd)) begin
        if (res) m_cnt[issue_rd] = m_cnt[issue_rd] + 2'd1;
        if (rel && m_cnt[wb_rd] != 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 2'd1;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_saturate();
    test_same_cycle();
    test_underflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
